// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous flag FIFO.
// Pointer and count widths derive from the FIFO depth.
package fifo_pkg;

    localparam int DEF_BITNUMBER = 8;
    localparam int DEF_LENGTH    = 8;
    localparam int DEF_AF_THRESH = 6;
    localparam int DEF_AE_THRESH = 2;

    localparam int PTR_W = $clog2(DEF_LENGTH);
    localparam int CNT_W = PTR_W + 1;

    function automatic int ptr_w(input int len);
        return $clog2(len);
    endfunction

endpackage

// File: rtl/fifo_sync_flags_if.sv
// Push/pop bus and status flags of the synchronous FIFO.
// The master is the stimulus side; the slave is the FIFO.
interface fifo_sync_flags_if #(
    parameter int BITNUMBER = 8,
    parameter int LENGTH    = 8
);

    localparam int CNT_W = $clog2(LENGTH) + 1;

    logic                 Fifo_wr;
    logic                 Fifo_rd;
    logic [BITNUMBER-1:0] Fifo_Data_in;
    logic [BITNUMBER-1:0] Fifo_Data_out;
    logic                 Fifo_valid;
    logic                 Fifo_full;
    logic                 Fifo_empty;
    logic                 Fifo_almost_full;
    logic                 Fifo_almost_empty;
    logic [CNT_W-1:0]     Fifo_count;
    logic                 Fifo_overflow;
    logic                 Fifo_underflow;

    modport master (
        output Fifo_wr, Fifo_rd, Fifo_Data_in,
        input  Fifo_Data_out, Fifo_valid, Fifo_full, Fifo_empty,
        input  Fifo_almost_full, Fifo_almost_empty, Fifo_count,
        input  Fifo_overflow, Fifo_underflow
    );

    modport slave (
        input  Fifo_wr, Fifo_rd, Fifo_Data_in,
        output Fifo_Data_out, Fifo_valid, Fifo_full, Fifo_empty,
        output Fifo_almost_full, Fifo_almost_empty, Fifo_count,
        output Fifo_overflow, Fifo_underflow
    );

endinterface

// File: rtl/fifo_mem_dp.sv
// Storage array: one synchronous write port, one async read port.
// Contents are deliberately not reset.
module fifo_mem_dp
    import fifo_pkg::*;
#(
    parameter int BITNUMBER = DEF_BITNUMBER,
    parameter int LENGTH    = DEF_LENGTH,
    parameter int AW        = ptr_w(LENGTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [BITNUMBER-1:0] wdata,
    input  logic [AW-1:0]        raddr,
    output logic [BITNUMBER-1:0] rdata
);

    logic [BITNUMBER-1:0] mem [LENGTH];

    // Write the addressed word on the rising edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with registered pop data, occupancy flags
// and sticky overflow/underflow errors.
module fifo_sync_flags
    import fifo_pkg::*;
#(
    parameter int BITNUMBER = DEF_BITNUMBER,
    parameter int LENGTH    = DEF_LENGTH,
    parameter int AF_THRESH = DEF_AF_THRESH,
    parameter int AE_THRESH = DEF_AE_THRESH
) (
    input logic                clk,
    input logic                reset,
    fifo_sync_flags_if.slave   bus
);

    localparam int PW = ptr_w(LENGTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [BITNUMBER-1:0] rdata;
    logic [BITNUMBER-1:0] data_out;
    logic                 valid;
    logic                 overflow;
    logic                 underflow;
    logic                 full;
    logic                 empty;
    logic                 do_wr;
    logic                 do_rd;

    assign full  = (count == CW'(LENGTH));
    assign empty = (count == '0);

    // A full FIFO still accepts a write when a pop frees a slot
    // in the same cycle; an empty FIFO never bypasses.
    assign do_rd = bus.Fifo_rd && !empty;
    assign do_wr = bus.Fifo_wr && (!full || bus.Fifo_rd);

    fifo_mem_dp #(
        .BITNUMBER (BITNUMBER),
        .LENGTH    (LENGTH),
        .AW        (PW)
    ) u_mem (
        .clk   (clk),
        .we    (do_wr),
        .waddr (wr_ptr),
        .wdata (bus.Fifo_Data_in),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // Pointers wrap naturally; count tracks net pushes minus pops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_wr && !do_rd) begin
                count <= count + CW'(1);
            end else if (do_rd && !do_wr) begin
                count <= count - CW'(1);
            end
        end
    end

    // Register popped data; valid pulses only on a real pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out <= '0;
            valid    <= 1'b0;
        end else begin
            valid <= do_rd;
            if (do_rd) begin
                data_out <= rdata;
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (bus.Fifo_wr && full && !bus.Fifo_rd) begin
                overflow <= 1'b1;
            end
            if (bus.Fifo_rd && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    assign bus.Fifo_Data_out     = data_out;
    assign bus.Fifo_valid        = valid;
    assign bus.Fifo_full         = full;
    assign bus.Fifo_empty        = empty;
    assign bus.Fifo_almost_full  = (count >= CW'(AF_THRESH));
    assign bus.Fifo_almost_empty = (count <= CW'(AE_THRESH));
    assign bus.Fifo_count        = count;
    assign bus.Fifo_overflow     = overflow;
    assign bus.Fifo_underflow    = underflow;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Scoreboard bench for fifo_sync_flags: directed pushes/pops,
// popped data checked by a monitor, flags checked inline.
module tb_fifo_sync_flags;

    logic clk;
    logic reset;

    fifo_sync_flags_if #(.BITNUMBER(8), .LENGTH(8)) b ();

    fifo_sync_flags #(
        .BITNUMBER (8),
        .LENGTH    (8),
        .AF_THRESH (6),
        .AE_THRESH (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] model [$];
    logic [7:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one cycle of stimulus and record the expected pop data.
    task automatic op(input logic wr, input logic rd, input logic [7:0] din);
        int sz;
        sz = model.size();
        b.Fifo_wr      = wr;
        b.Fifo_rd      = rd;
        b.Fifo_Data_in = din;
        if (rd && sz > 0) exp_q.push_back(model.pop_front());
        if (wr && (sz < 8 || rd)) model.push_back(din);
        @(posedge clk);
        #1;
        b.Fifo_wr = 1'b0;
        b.Fifo_rd = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        model.delete();
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        idle(1);
    endtask

    // Monitor: every valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (reset && b.Fifo_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_data: valid with no pop expected, got %0h",
                         b.Fifo_Data_out);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (b.Fifo_Data_out !== e) begin
                    n_fail++;
                    $display("FAIL pop_data: got %0h expected %0h",
                             b.Fifo_Data_out, e);
                end
            end
        end
    end

    initial begin
        reset          = 1'b0;
        b.Fifo_wr      = 1'b0;
        b.Fifo_rd      = 1'b0;
        b.Fifo_Data_in = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        idle(2);

        chk("rst_empty", b.Fifo_empty, 1);
        chk("rst_count", b.Fifo_count, 0);
        chk("rst_dout", b.Fifo_Data_out, 0);
        chk("rst_ovf", b.Fifo_overflow, 0);
        chk("rst_unf", b.Fifo_underflow, 0);
        chk("rst_full", b.Fifo_full, 0);
        chk("rst_ae", b.Fifo_almost_empty, 1);
        chk("rst_af", b.Fifo_almost_full, 0);

        op(1, 0, 8'h0A);
        op(1, 0, 8'h0B);
        op(1, 0, 8'h0C);
        op(1, 0, 8'h0D);
        op(0, 1, 8'h00);
        chk("pop1_dout", b.Fifo_Data_out, 8'h0A);
        chk("pop1_valid", b.Fifo_valid, 1);
        chk("pop1_count", b.Fifo_count, 3);
        idle(1);
        chk("pop1_valid_drop", b.Fifo_valid, 0);
        chk("pop1_hold", b.Fifo_Data_out, 8'h0A);
        repeat (3) op(0, 1, 8'h00);
        chk("drain_empty", b.Fifo_empty, 1);

        for (int i = 1; i <= 8; i++) begin
            op(1, 0, 8'(i));
            if (i == 2) chk("ae_at2", b.Fifo_almost_empty, 1);
            if (i == 3) chk("ae_at3", b.Fifo_almost_empty, 0);
            if (i == 5) chk("af_at5", b.Fifo_almost_full, 0);
            if (i == 6) chk("af_at6", b.Fifo_almost_full, 1);
            if (i == 7) chk("full_at7", b.Fifo_full, 0);
        end
        chk("full_at8", b.Fifo_full, 1);
        chk("count_at8", b.Fifo_count, 8);
        chk("ovf_before", b.Fifo_overflow, 0);
        op(1, 0, 8'h09);
        chk("ovf_set", b.Fifo_overflow, 1);
        chk("ovf_count", b.Fifo_count, 8);
        for (int i = 1; i <= 10; i++) begin
            op(0, 1, 8'h00);
            if (i == 8) chk("unf_not_yet", b.Fifo_underflow, 0);
        end
        idle(1);
        chk("unf_set", b.Fifo_underflow, 1);
        chk("unf_dout", b.Fifo_Data_out, 8'h08);
        chk("unf_empty", b.Fifo_empty, 1);
        chk("ovf_sticky", b.Fifo_overflow, 1);

        do_reset();
        for (int i = 1; i <= 8; i++) op(1, 0, 8'(i));
        op(1, 1, 8'h0F);
        chk("fullrw_dout", b.Fifo_Data_out, 8'h01);
        chk("fullrw_count", b.Fifo_count, 8);
        chk("fullrw_ovf", b.Fifo_overflow, 0);
        repeat (8) op(0, 1, 8'h00);
        chk("wrap_last", b.Fifo_Data_out, 8'h0F);
        chk("wrap_empty", b.Fifo_empty, 1);

        op(1, 1, 8'h05);
        chk("emptyrw_count", b.Fifo_count, 1);
        chk("emptyrw_unf", b.Fifo_underflow, 1);
        chk("emptyrw_valid", b.Fifo_valid, 0);
        op(0, 1, 8'h00);
        chk("emptyrw_pop", b.Fifo_Data_out, 8'h05);
        idle(1);

        for (int i = 0; i < 5; i++) op(1, 0, 8'h30 + 8'(i));
        chk("mid_count", b.Fifo_count, 5);
        #2;
        reset = 1'b0;
        model.delete();
        exp_q.delete();
        #1;
        chk("async_count", b.Fifo_count, 0);
        chk("async_empty", b.Fifo_empty, 1);
        chk("async_dout", b.Fifo_Data_out, 0);
        chk("async_unf", b.Fifo_underflow, 0);
        chk("async_valid", b.Fifo_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        idle(1);
        op(1, 0, 8'h77);
        op(0, 1, 8'h00);
        chk("post_rst_pop", b.Fifo_Data_out, 8'h77);
        idle(2);

        chk("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
- Synchronous single-clock FIFO, the storage responder driven by the FIFO stimulus generator.
- Accepts Fifo_wr/Fifo_Data_in pushes and Fifo_rd pops, and presents popped data registered on Fifo_Data_out.
- Flags: full/empty, programmable almost-full/almost-empty, occupancy count, and sticky overflow/underflow errors, for the upstream flow-control logic.

Parameters:
- BITNUMBER, 8, data word width.
- LENGTH, 8, depth in words; must be a power of 2 and at least 4.
- AF_THRESH, 6, Fifo_almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2, Fifo_almost_empty asserts when count <= AE_THRESH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-low reset.
- Fifo_wr  in  1  push request.
- Fifo_rd  in  1  pop request.
- Fifo_Data_in  in  BITNUMBER  push data.
- Fifo_Data_out  out  BITNUMBER  last popped word, registered.
- Fifo_valid  out  1  high for exactly one cycle when Fifo_Data_out has just been updated by a pop.
- Fifo_full  out  1  count == LENGTH.
- Fifo_empty  out  1  count == 0.
- Fifo_almost_full  out  1  count >= AF_THRESH.
- Fifo_almost_empty  out  1  count <= AE_THRESH.
- Fifo_count  out  log2(LENGTH)+1  current occupancy.
- Fifo_overflow  out  1  sticky: a write was dropped.
- Fifo_underflow  out  1  sticky: a read was dropped.

Behaviour:
- Reset:
  - reset=0 asynchronously clears wr_ptr, rd_ptr, count, Fifo_Data_out, Fifo_valid, Fifo_overflow and Fifo_underflow to 0.
  - After reset: Fifo_empty=1, Fifo_almost_empty=1, Fifo_full=0, Fifo_almost_full=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all contents immediately.
- Pointers:
  - log2(LENGTH) bits each; wrap naturally from LENGTH-1 to 0.
  - count is held separately; flags decode combinationally from count.
- Write (Fifo_wr=1) at posedge:
  - Not full: mem[wr_ptr] <= Fifo_Data_in, wr_ptr++.
  - Full and Fifo_rd=0: write dropped, Fifo_overflow <= 1.
- Read (Fifo_rd=1) at posedge:
  - Not empty: Fifo_Data_out <= mem[rd_ptr], rd_ptr++, Fifo_valid <= 1.
  - Empty: read dropped, Fifo_underflow <= 1, Fifo_Data_out holds, Fifo_valid <= 0.
  - Latency: data visible one cycle after the rd edge.
  - Fifo_Data_out holds its value when no pop occurs.
- Simultaneous rd and wr:
  - When full: both occur; the read returns the oldest word, the new word takes the freed slot, count unchanged, no overflow.
  - When empty: the write occurs and the read is dropped (no bypass), Fifo_underflow <= 1, count becomes 1.
  - Otherwise: both occur, count unchanged.
- count update: +1 on write-only, -1 on read-only, unchanged on both or neither.
- Errors: overflow and underflow are sticky until reset; they do not block further operation.
- No state machine beyond the count/pointer registers; all outputs are registered or pure decodes of count.

Decomposition:
- Shared package fifo_pkg holds:
  - PTR_W = clog2(LENGTH) and CNT_W = PTR_W+1.
  - Default BITNUMBER/LENGTH constants.
  - Threshold defaults.
- Sub-module fifo_mem_dp:
  - Dual-port register array, LENGTH x BITNUMBER.
  - One synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
  - No reset.
  - fifo_sync_flags instantiates it and registers rdata into Fifo_Data_out.

Test Plan:
- Reset then idle 2 cycles -> Fifo_empty=1, Fifo_count=0, Fifo_Data_out=0, both error flags 0.
- Push 0xA,0xB,0xC,0xD, then pop once -> next cycle Fifo_Data_out=0xA, Fifo_valid=1 for one cycle, Fifo_count=3.
- Push 1..8 into an empty FIFO, then push 9 -> Fifo_full=1 after 8 writes, Fifo_count=8, 9 dropped, Fifo_overflow=1; drain 8 pops returns exactly 1..8 in order.
- Pop 10 times from 8 entries -> last 2 pops dropped, Fifo_underflow=1, Fifo_Data_out stays 8, Fifo_empty=1.
- Full FIFO (1..8) with wr=1 data 0xF and rd=1 in the same cycle -> Fifo_Data_out=1, count stays 8, no overflow; final drain ends with 0xF (wrap-around exercised).
- Empty FIFO with wr=1 data 0x5 and rd=1 together -> count=1, Fifo_underflow=1; next pop returns 0x5.
- Assert reset low mid-fill at count=5 -> outputs clear immediately without waiting for clk.
- Threshold check -> Fifo_almost_full rises at count 6, Fifo_almost_empty falls at count 3.
